// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//   Raster scan controller clocked at the pixel clock. Walks a horizontal and
//   vertical counter through sync / back porch / active / front porch, issues
//   frame-buffer read addresses for the active region, and delays the
//   timing signals so that sync, data enable and colour leave the block
//   cycle-aligned despite the frame-buffer read latency.
//
// Ports
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   blank        forces r/g/b to zero (timing keeps running)
//   scale_sel    0 = 1x, 1 = 2x, 2 = 4x, 3 = 1x; sampled at frame start only
//   data_in      frame-buffer pixel, valid RD_LAT clocks after its addr
//   addr         {row, col} read address, zero outside the active region
//   rd_en        addr is a valid active-region request
//   r, g, b      colour, zero outside the active region or while blanked
//   hs, vs       sync outputs, asserted level HS_POL / VS_POL
//   de           data enable, aligned with r/g/b
//   frame_start  one-clock pulse for the first pixel slot of a frame
//   line_start   one-clock pulse at the first active pixel of an active line
//
// Read contract: rd_en/addr are combinational from the counters. There is
// no back-pressure; the frame buffer must return the word for every cycle
// in which rd_en is high exactly RD_LAT clocks later on data_in.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int RD_LAT   = 1,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int COL_W    = 11,
    parameter int ROW_W    = 10,
    localparam int PIX_W   = R_W + G_W + B_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blank,
    input  logic [1:0]             scale_sel,
    input  logic [PIX_W-1:0]       data_in,
    output logic [ROW_W+COL_W-1:0] addr,
    output logic                   rd_en,
    output logic [R_W-1:0]         r,
    output logic [G_W-1:0]         g,
    output logic [B_W-1:0]         b,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_CW    = $clog2(H_TOTAL);
    localparam int V_CW    = $clog2(V_TOTAL);
    localparam int H_ACT_S = H_SYNC + H_BP;
    localparam int H_ACT_E = H_ACT_S + H_ACTIVE;
    localparam int V_ACT_S = V_SYNC + V_BP;
    localparam int V_ACT_E = V_ACT_S + V_ACTIVE;

    logic [H_CW-1:0]  h_cnt_q, h_cnt_d;
    logic [V_CW-1:0]  v_cnt_q, v_cnt_d;
    logic [1:0]       scale_q, scale_d;   // shift amount 0/1/2

    // Delay lines: bit 0 is loaded from the counters, bit RD_LAT drives the pins.
    logic [RD_LAT:0]  act_q, act_d;
    logic [RD_LAT:0]  hs_q, hs_d;
    logic [RD_LAT:0]  vs_q, vs_d;
    logic [RD_LAT:0]  fs_q, fs_d;
    logic [RD_LAT:0]  ls_q, ls_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    logic             h_last, v_last, frame_now, active;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_comb begin
        h_last    = (h_cnt_q == H_CW'(H_TOTAL - 1));
        v_last    = (v_cnt_q == V_CW'(V_TOTAL - 1));
        frame_now = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_last ? '0 : h_cnt_q + H_CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + V_CW'(1);
        end

        // Scale only changes on the frame boundary so a frame is never mixed.
        scale_d = scale_q;
        if (frame_now) begin
            case (scale_sel)
                2'd1:    scale_d = 2'd1;
                2'd2:    scale_d = 2'd2;
                default: scale_d = 2'd0;
            endcase
        end

        active = (h_cnt_q >= H_CW'(H_ACT_S)) && (h_cnt_q < H_CW'(H_ACT_E)) &&
                 (v_cnt_q >= V_CW'(V_ACT_S)) && (v_cnt_q < V_CW'(V_ACT_E));

        // Offsets are computed at 32 bits and truncated after the shift.
        col = COL_W'((32'(h_cnt_q) - 32'(H_ACT_S)) >> scale_q);
        row = ROW_W'((32'(v_cnt_q) - 32'(V_ACT_S)) >> scale_q);

        rd_en = active;
        addr  = active ? {row, col} : '0;

        act_d = {act_q[RD_LAT-1:0], active};
        hs_d  = {hs_q[RD_LAT-1:0], (h_cnt_q < H_CW'(H_SYNC)) ? HS_POL : ~HS_POL};
        vs_d  = {vs_q[RD_LAT-1:0], (v_cnt_q < V_CW'(V_SYNC)) ? VS_POL : ~VS_POL};
        fs_d  = {fs_q[RD_LAT-1:0], frame_now};
        ls_d  = {ls_q[RD_LAT-1:0], active && (h_cnt_q == H_CW'(H_ACT_S))};

        // data_in pairs with the active flag that is RD_LAT stages old; the
        // register here supplies the final stage so colour lines up with de.
        pix_d = (act_q[RD_LAT-1] && !blank) ? data_in : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            scale_q <= 2'd0;
            act_q   <= '0;
            hs_q    <= {(RD_LAT+1){~HS_POL}};
            vs_q    <= {(RD_LAT+1){~VS_POL}};
            fs_q    <= '0;
            ls_q    <= '0;
            pix_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            scale_q <= scale_d;
            act_q   <= act_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            pix_q   <= pix_d;
        end
    end

    assign r           = pix_q[PIX_W-1 -: R_W];
    assign g           = pix_q[B_W +: G_W];
    assign b           = pix_q[B_W-1:0];
    assign de          = act_q[RD_LAT];
    assign hs          = hs_q[RD_LAT];
    assign vs          = vs_q[RD_LAT];
    assign frame_start = fs_q[RD_LAT];
    assign line_start  = ls_q[RD_LAT];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl. Three instances share clk/rst:
//   big : default 1280x1024 timing, RD_LAT=1, data tied to zero
//   sm  : small timing H 8/2/2/2, V 4/1/1/1, RD_LAT=2, RAM returns addr[7:0]
//   np  : small timing, RD_LAT=1, negative sync polarity, RAM returns addr[7:0]
// Small timing: H_TOTAL=14, V_TOTAL=7, frame=98 clocks, active h 4..11, v 2..5.
module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // big instance
    logic [20:0] addr_big;
    logic        rd_en_big, hs_big, vs_big, de_big, fs_big, ls_big;
    logic [2:0]  r_big, g_big;
    logic [1:0]  b_big;
    logic [7:0]  data_big = 8'd0;
    logic        blank_big = 1'b0;
    logic [1:0]  scale_big = 2'd0;

    // sm instance
    logic [20:0] addr_sm;
    logic        rd_en_sm, hs_sm, vs_sm, de_sm, fs_sm, ls_sm;
    logic [2:0]  r_sm, g_sm;
    logic [1:0]  b_sm;
    logic [7:0]  data_sm;
    logic        blank_sm = 1'b0;
    logic [1:0]  scale_sm = 2'd0;
    logic [7:0]  sm_p0 = 8'd0, sm_p1 = 8'd0;

    // np instance
    logic [20:0] addr_np;
    logic        rd_en_np, hs_np, vs_np, de_np, fs_np, ls_np;
    logic [2:0]  r_np, g_np;
    logic [1:0]  b_np;
    logic [7:0]  data_np;
    logic        blank_np = 1'b0;
    logic [1:0]  scale_np = 2'd0;
    logic [7:0]  np_p0 = 8'd0;

    // Frame-buffer models: word = addr[7:0], returned RD_LAT clocks later.
    always @(posedge clk) begin
        sm_p0 <= addr_sm[7:0];
        sm_p1 <= sm_p0;
        np_p0 <= addr_np[7:0];
    end
    assign data_sm = sm_p1;
    assign data_np = np_p0;

    vga_scan_ctrl u_big (
        .clk(clk), .rst(rst), .blank(blank_big), .scale_sel(scale_big),
        .data_in(data_big), .addr(addr_big), .rd_en(rd_en_big),
        .r(r_big), .g(g_big), .b(b_big), .hs(hs_big), .vs(vs_big),
        .de(de_big), .frame_start(fs_big), .line_start(ls_big)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(2)
    ) u_sm (
        .clk(clk), .rst(rst), .blank(blank_sm), .scale_sel(scale_sm),
        .data_in(data_sm), .addr(addr_sm), .rd_en(rd_en_sm),
        .r(r_sm), .g(g_sm), .b(b_sm), .hs(hs_sm), .vs(vs_sm),
        .de(de_sm), .frame_start(fs_sm), .line_start(ls_sm)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_np (
        .clk(clk), .rst(rst), .blank(blank_np), .scale_sel(scale_np),
        .data_in(data_np), .addr(addr_np), .rd_en(rd_en_np),
        .r(r_np), .g(g_np), .b(b_np), .hs(hs_np), .vs(vs_np),
        .de(de_np), .frame_start(fs_np), .line_start(ls_np)
    );

    logic [7:0] rgb_sm, rgb_np, rgb_big;
    assign rgb_sm  = {r_sm, g_sm, b_sm};
    assign rgb_np  = {r_np, g_np, b_np};
    assign rgb_big = {r_big, g_big, b_big};

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int hs_cnt_big = 0;
    int vs_cnt_big = 0;

    initial begin
        // ---------------- reset values ----------------
        repeat (3) step_clk();
        chk("rst_big_addr",  addr_big, 0);
        chk("rst_big_rden",  rd_en_big, 0);
        chk("rst_big_rgb",   rgb_big, 0);
        chk("rst_big_de",    de_big, 0);
        chk("rst_big_fs",    fs_big, 0);
        chk("rst_big_ls",    ls_big, 0);
        chk("rst_big_hs",    hs_big, 0);
        chk("rst_big_vs",    vs_big, 0);
        chk("rst_sm_addr",   addr_sm, 0);
        chk("rst_sm_rden",   rd_en_sm, 0);
        chk("rst_sm_rgb",    rgb_sm, 0);
        chk("rst_sm_de",     de_sm, 0);
        chk("rst_sm_hs",     hs_sm, 0);
        chk("rst_sm_vs",     vs_sm, 0);
        chk("rst_np_hs",     hs_np, 1);
        chk("rst_np_vs",     vs_np, 1);

        // ---------------- main run; t = counter state since release ----------
        rst = 1'b0;
        for (int t = 0; t <= 5134; t++) begin
            if (t >= 2 && t <= 1689 && hs_big) hs_cnt_big++;
            if (t <= 5100 && vs_big) vs_cnt_big++;
            case (t)
                0: begin
                    chk("t0_sm_addr", addr_sm, 0);
                    chk("t0_sm_rden", rd_en_sm, 0);
                    chk("t0_sm_hs", hs_sm, 0);
                    chk("t0_np_hs", hs_np, 1);
                end
                1: chk("t1_big_hs", hs_big, 0);
                2: begin
                    chk("t2_sm_fs", fs_sm, 0);
                    chk("t2_sm_hs", hs_sm, 0);
                    chk("t2_sm_vs", vs_sm, 0);
                    chk("t2_np_hs", hs_np, 0);
                    chk("t2_np_vs", vs_np, 0);
                    chk("t2_big_hs", hs_big, 1);
                end
                3: begin
                    chk("t3_sm_fs", fs_sm, 1);
                    chk("t3_sm_hs", hs_sm, 1);
                    chk("t3_sm_vs", vs_sm, 1);
                    chk("t3_np_hs", hs_np, 0);
                end
                4: begin
                    chk("t4_sm_fs", fs_sm, 0);
                    chk("t4_sm_hs", hs_sm, 1);
                    chk("t4_np_hs", hs_np, 1);
                end
                5:  chk("t5_sm_hs", hs_sm, 0);
                15: chk("t15_np_vs", vs_np, 0);
                16: begin
                    chk("t16_sm_vs", vs_sm, 1);
                    chk("t16_np_vs", vs_np, 1);
                end
                17: chk("t17_sm_vs", vs_sm, 0);
                31: chk("t31_sm_rden", rd_en_sm, 0);
                32: begin
                    chk("t32_sm_rden", rd_en_sm, 1);
                    chk("t32_sm_addr", addr_sm, 0);
                end
                33: begin
                    chk("t33_sm_addr", addr_sm, 1);
                    chk("t33_np_de", de_np, 0);
                end
                34: begin
                    chk("t34_sm_de", de_sm, 0);
                    chk("t34_np_de", de_np, 1);
                end
                35: begin
                    chk("t35_sm_de", de_sm, 1);
                    chk("t35_sm_ls", ls_sm, 1);
                    chk("t35_sm_fs", fs_sm, 0);
                    chk("t35_sm_rgb", rgb_sm, 0);
                    chk("t35_np_rgb", rgb_np, 1);
                end
                36: begin
                    chk("t36_sm_rgb", rgb_sm, 1);
                    chk("t36_sm_ls", ls_sm, 0);
                end
                38: chk("t38_sm_rgb", rgb_sm, 3);
                39: begin
                    chk("t39_sm_addr", addr_sm, 7);
                    chk("t39_sm_rden", rd_en_sm, 1);
                end
                40: begin
                    chk("t40_sm_rden", rd_en_sm, 0);
                    chk("t40_sm_addr", addr_sm, 0);
                end
                42: begin
                    chk("t42_sm_rgb", rgb_sm, 7);
                    chk("t42_sm_de", de_sm, 1);
                end
                43: begin
                    chk("t43_sm_de", de_sm, 0);
                    chk("t43_sm_rgb", rgb_sm, 0);
                end
                48: blank_sm = 1'b1;
                50: begin
                    chk("t50_blank_de", de_sm, 1);
                    chk("t50_blank_rgb", rgb_sm, 0);
                end
                56: blank_sm = 1'b0;
                64: begin
                    chk("t64_sm_de", de_sm, 1);
                    chk("t64_sm_rgb", rgb_sm, 1);
                end
                70: scale_sm = 2'd1;
                75: chk("t75_midframe_1x_addr", addr_sm, 6145);
                130: begin
                    chk("t130_2x_rden", rd_en_sm, 1);
                    chk("t130_2x_addr", addr_sm, 0);
                end
                131: chk("t131_2x_addr", addr_sm, 0);
                132: chk("t132_2x_addr", addr_sm, 1);
                135: chk("t135_2x_rgb", rgb_sm, 1);
                137: begin
                    chk("t137_2x_addr", addr_sm, 3);
                    chk("t137_2x_rgb", rgb_sm, 2);
                end
                146: chk("t146_2x_row1_addr", addr_sm, 1);
                150: scale_sm = 2'd0;
                158: chk("t158_2x_row2_addr", addr_sm, 2048);
                161: chk("t161_2x_row2_addr", addr_sm, 2049);
                172: chk("t172_2x_row3_addr", addr_sm, 2048);
                229: chk("t229_1x_addr", addr_sm, 1);
                231: chk("t231_1x_addr", addr_sm, 3);
                257: chk("t257_1x_row2_addr", addr_sm, 4097);
                1689: chk("t1689_big_hs", hs_big, 0);
                1690: chk("t1690_big_hs", hs_big, 1);
                5134: begin
                    chk("t5134_sm_rden", rd_en_sm, 1);
                    chk("t5134_sm_addr", addr_sm, 6);
                    rst = 1'b1;
                end
                default: ;
            endcase
            step_clk();
        end
        chk("big_hs_width", hs_cnt_big, 112);
        chk("big_vs_width", vs_cnt_big, 5064);

        // ---------------- mid-line reset: flush and refill ----------------
        rst = 1'b0;
        for (int t = 0; t <= 36; t++) begin
            if (t == 0) begin
                chk("rr_addr", addr_sm, 0);
                chk("rr_rden", rd_en_sm, 0);
                chk("rr_hs", hs_sm, 0);
                chk("rr_fs", fs_sm, 0);
            end
            if (t < 35) begin
                chk("rr_de_idle", de_sm, 0);
                chk("rr_rgb_idle", rgb_sm, 0);
            end
            if (t == 3) chk("rr_fs_pulse", fs_sm, 1);
            if (t == 35) chk("rr_de_fill", de_sm, 1);
            if (t == 36) chk("rr_rgb_fill", rgb_sm, 1);
            step_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
